// File: rtl/stage_buf.sv
// stage_buf: registered valid/ready elastic buffer placed between NPC pipeline units.
// DEPTH entries of DATA_W bits, circular pointers that wrap correctly for any DEPTH,
// synchronous flush for pc redirects, asynchronous active-high reset.
// Optional build macro STAGE_BUF_BYPASS_EN: when empty, an incoming beat is presented
// downstream combinationally (0-cycle latency) and skips the storage if taken at once.
module stage_buf #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_flush,
   input  logic              i_pre_valid,
   output logic              o_pre_ready,
   input  logic [DATA_W-1:0] i_pre_data,
   output logic              o_post_valid,
   input  logic              i_post_ready,
   output logic [DATA_W-1:0] o_post_data,
   output logic [CNT_W-1:0]  o_count,
   output logic              o_full,
   output logic              o_empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, wr_ptr_nxt;
   logic [PTR_W-1:0]  rd_ptr, rd_ptr_nxt;
   logic [CNT_W-1:0]  count, count_nxt;
   logic [DATA_W-1:0] head_q, head_nxt;
   logic              empty, full;
   logic              push, pop, pass;
   logic              wr_en, rd_en;

   // Advance a circular pointer, wrapping after the last real entry (not at 2**PTR_W).
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      ptr_inc = (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty       = (count == '0);
   assign full        = (count == CNT_FULL);
   assign o_empty     = empty;
   assign o_full      = full;
   assign o_count     = count;
   // Ready depends only on state, never on the downstream ready.
   assign o_pre_ready = !full;

`ifdef STAGE_BUF_BYPASS_EN
   logic byp_sel;
   assign byp_sel      = empty & i_pre_valid & !i_rst;
   assign o_post_valid = !i_flush & !i_rst & (!empty | i_pre_valid);
   assign o_post_data  = byp_sel ? i_pre_data : head_q;
`else
   assign o_post_valid = !empty;
   assign o_post_data  = head_q;
`endif

   assign push = i_pre_valid & o_pre_ready;
   assign pop  = o_post_valid & i_post_ready;

`ifdef STAGE_BUF_BYPASS_EN
   // An empty-buffer beat taken downstream in the same cycle never touches storage.
   assign pass = empty & push & pop;
`else
   assign pass = 1'b0;
`endif

   assign wr_en = push & !pass & !i_flush;
   assign rd_en = pop  & !pass & !i_flush;

   // Next pointer/occupancy/head computation; flush overrides any handshake.
   always_comb begin
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      count_nxt  = count;
      head_nxt   = head_q;
      if (i_flush) begin
         wr_ptr_nxt = '0;
         rd_ptr_nxt = '0;
         count_nxt  = '0;
      end else begin
         if (wr_en) wr_ptr_nxt = ptr_inc(wr_ptr);
         if (rd_en) rd_ptr_nxt = ptr_inc(rd_ptr);
         case ({wr_en, rd_en})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
         endcase
         // The incoming beat becomes the head when nothing older survives this edge;
         // otherwise the next surviving entry is already in storage and not being written.
         if (wr_en && (empty || ((count == CNT_ONE) && rd_en))) begin
            head_nxt = i_pre_data;
         end else if (rd_en) begin
            head_nxt = mem[rd_ptr_nxt];
         end
      end
   end

   // Control and head register: cleared immediately on reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head_q <= '0;
      end else begin
         wr_ptr <= wr_ptr_nxt;
         rd_ptr <= rd_ptr_nxt;
         count  <= count_nxt;
         head_q <= head_nxt;
      end
   end

   // Entry storage: cleared on reset, written at the write pointer on an accepted beat.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_ptr] <= i_pre_data;
      end
   end

`ifndef SYNTHESIS
   logic              stall_q;
   logic [DATA_W-1:0] stall_data_q;

   // Remember whether upstream was stalled with a beat at the previous edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         stall_q      <= 1'b0;
         stall_data_q <= '0;
      end else begin
         stall_q      <= i_pre_valid & !o_pre_ready & !i_flush;
         stall_data_q <= i_pre_data;
      end
   end

   // A stalled beat must be held: valid stays high and payload stays stable.
   always @(posedge i_clk) begin
      if (!i_rst && stall_q) begin
         assert (i_pre_valid)
            else $error("stage_buf: i_pre_valid dropped without a push");
         assert (i_pre_data == stall_data_q)
            else $error("stage_buf: i_pre_data changed while stalled");
      end
   end
`endif

endmodule

// File: tb/tb_stage_buf.sv
// tb_stage_buf: scoreboard bench for stage_buf (DEPTH=3, DATA_W=32).
// The reference model is a queue of beats with capacity DEPTH; the monitor checks
// status outputs against it every cycle and pops/compares on each downstream transfer.
module tb_stage_buf;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 3;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              pre_valid;
   logic              pre_ready;
   logic [DATA_W-1:0] pre_data;
   logic              post_valid;
   logic              post_ready;
   logic [DATA_W-1:0] post_data;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              empty;

   int n_checks = 0;
   int n_errors = 0;

   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] out_log[$];
   bit                m_pushed  = 1'b0;
   bit                m_flushed = 1'b0;
   int                max_cnt   = 0;
   bit                tog       = 1'b0;

   stage_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_flush     (flush),
      .i_pre_valid (pre_valid),
      .o_pre_ready (pre_ready),
      .i_pre_data  (pre_data),
      .o_post_valid(post_valid),
      .i_post_ready(post_ready),
      .o_post_data (post_data),
      .o_count     (count),
      .o_full      (full),
      .o_empty     (empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor/scoreboard: runs 1 time unit before each rising edge.
   always @(negedge clk) begin
      bit                exp_ready, exp_valid, do_push;
      logic [DATA_W-1:0] exp_data, got;
      #4;
      if (rst) begin
         exp_q.delete();
         m_pushed  = 1'b0;
         m_flushed = 1'b0;
         chk("rst_count", count, 0);
         chk("rst_post_valid", post_valid, 0);
         chk("rst_pre_ready", pre_ready, 1);
         chk("rst_empty", empty, 1);
         chk("rst_full", full, 0);
         chk("rst_post_data", post_data, 0);
      end else begin
         exp_ready = (exp_q.size() < DEPTH);
`ifdef STAGE_BUF_BYPASS_EN
         exp_valid = !flush && (exp_q.size() != 0 || pre_valid);
         exp_data  = (exp_q.size() != 0) ? exp_q[0] : pre_data;
`else
         exp_valid = (exp_q.size() != 0);
         exp_data  = (exp_q.size() != 0) ? exp_q[0] : '0;
`endif
         if (int'(count) > max_cnt) max_cnt = int'(count);
         chk("count", count, exp_q.size());
         chk("full", full, exp_q.size() == DEPTH);
         chk("empty", empty, exp_q.size() == 0);
         chk("pre_ready", pre_ready, exp_ready);
         chk("post_valid", post_valid, exp_valid);
         if (exp_valid) chk("post_data", post_data, exp_data);
         m_flushed = flush;
         if (flush) begin
            exp_q.delete();
            m_pushed = 1'b0;
         end else begin
            do_push = pre_valid && exp_ready;
            if (post_valid && post_ready) begin
`ifdef STAGE_BUF_BYPASS_EN
               if (exp_q.size() == 0 && do_push) begin
                  chk("bypass_pop", post_data, pre_data);
                  out_log.push_back(pre_data);
                  do_push = 1'b0;
               end else
`endif
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL spurious_pop actual=%h expected=none", post_data);
               end else begin
                  got = exp_q.pop_front();
                  chk("pop_data", post_data, got);
                  out_log.push_back(post_data);
               end
            end
            if (do_push) exp_q.push_back(pre_data);
            m_pushed = pre_valid && exp_ready;
         end
      end
   end

   task automatic tick(input logic v, input logic [31:0] d, input logic rdy, input logic fl);
      @(negedge clk);
      pre_valid  = v;
      pre_data   = d;
      post_ready = rdy;
      flush      = fl;
   endtask

   // Present one beat until it is taken; rmode 0=ready low, 1=ready high, 2=toggle.
   task automatic send(input logic [31:0] d, input int rmode, output int n);
      n = 0;
      do begin
         tick(1'b1, d, (rmode == 2) ? tog : (rmode == 1), 1'b0);
         tog = !tog;
         @(posedge clk);
         n++;
      end while (!m_pushed && n < 50);
      if (!m_pushed) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout actual=stalled expected=accepted data=%h", d);
      end
   endtask

   task automatic idle(input logic rdy, input int cycles);
      for (int i = 0; i < cycles; i++) tick(1'b0, '0, rdy, 1'b0);
   endtask

   initial begin
      int n;
      rst = 1'b1; flush = 1'b0; pre_valid = 1'b0; pre_data = '0; post_ready = 1'b0;
      #3;
      chk("init_count", count, 0);
      chk("init_post_valid", post_valid, 0);
      chk("init_pre_ready", pre_ready, 1);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // Single beat with downstream ready.
      tick(1'b1, 32'h13, 1'b1, 1'b0);
      @(posedge clk); #1;
`ifndef STAGE_BUF_BYPASS_EN
      chk("t1_valid", post_valid, 1);
      chk("t1_data", post_data, 32'h13);
      chk("t1_count", count, 1);
`endif
      tick(1'b0, '0, 1'b1, 1'b0);
      @(posedge clk); #1;
      chk("t1_count_after", count, 0);
      chk("t1_valid_after", post_valid, 0);

      // Fill to full, hold a 4th beat, then drain in order.
      idle(1'b1, 2);
      out_log.delete();
      send(32'hA, 0, n); send(32'hB, 0, n); send(32'hC, 0, n);
      tick(1'b1, 32'hD, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("t2_full", full, 1);
      chk("t2_pre_ready", pre_ready, 0);
      chk("t2_count", count, 3);
      send(32'hD, 1, n);
      chk("t2_d_edges", n, 2);
      idle(1'b1, 6);
      chk("t2_pops", out_log.size(), 4);
      for (int i = 0; i < 4 && i < out_log.size(); i++) chk("t2_order", out_log[i], 32'hA + i);

      // Wrap-around stream with toggling ready.
      out_log.delete();
      max_cnt = 0;
      for (int i = 1; i <= 10; i++) send(i, 2, n);
      idle(1'b1, 6);
      chk("t3_pops", out_log.size(), 10);
      for (int i = 0; i < 10 && i < out_log.size(); i++) chk("t3_order", out_log[i], i + 1);
      chk("t3_max_count_ok", max_cnt <= DEPTH, 1);

      // Flush drops stored beats and the concurrent beat.
      send(32'h21, 0, n); send(32'h22, 0, n);
      out_log.delete();
      tick(1'b1, 32'h55, 1'b1, 1'b1);
      @(posedge clk); #1;
      chk("t4_count", count, 0);
      chk("t4_valid", post_valid, 0);
      idle(1'b1, 5);
      chk("t4_no_output", out_log.size(), 0);

      // Asynchronous reset between edges.
      send(32'h31, 0, n); send(32'h32, 0, n);
      @(negedge clk);
      pre_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("t5_valid", post_valid, 0);
      chk("t5_pre_ready", pre_ready, 1);
      chk("t5_count", count, 0);
      @(negedge clk);
      rst = 1'b0;

`ifdef STAGE_BUF_BYPASS_EN
      // Zero-latency pass-through into an empty buffer.
      idle(1'b1, 2);
      tick(1'b1, 32'h73, 1'b1, 1'b0);
      #1;
      chk("t6_valid", post_valid, 1);
      chk("t6_data", post_data, 32'h73);
      @(posedge clk); #1;
      chk("t6_count", count, 0);
      tick(1'b0, '0, 1'b1, 1'b0);
`endif

      // Randomized traffic with occasional flushes.
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         if (!pre_valid || m_pushed || m_flushed) begin
            pre_valid = ($urandom_range(0, 3) != 0);
            pre_data  = $urandom;
         end
         post_ready = $urandom_range(0, 1);
         flush      = ($urandom_range(0, 31) == 0);
      end
      idle(1'b1, 8);
      @(posedge clk); #1;
      chk("final_count", count, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
